// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the adder sequencing controller.
package adder_seq_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef logic grant_id_t;

endpackage

// File: rtl/adder_seq_ctrl_arbiter.sv
// Two-way round-robin arbiter: a lone requester wins, on contention the one
// that did not win last time wins. Purely combinational.
module rr_arbiter2
  import adder_seq_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  grant_id_t  last_grant,
  output logic [1:0] grant,
  output grant_id_t  grant_id
);

  always_comb begin
    grant    = '0;
    grant_id = 1'b0;
    unique case ({valid1, valid0})
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
    if (valid0 || valid1) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Shares one external adder between two requesters: accept, hold operands for
// ADD_LAT cycles, capture, respond. ADDER_SEQ_SUB_EN adds per-request subtract.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned ADD_LAT = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
`ifdef ADDER_SEQ_SUB_EN
  input  logic             req0_sub,
  input  logic             req1_sub,
`endif
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_cout,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_cout,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ADD_LAT - 1);

  state_t           state;
  grant_id_t        last_grant;
  grant_id_t        gid;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;

  logic [1:0]       arb_grant;
  grant_id_t        arb_id;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_cin;
  logic             sel_sub;
  logic             rsp_ready_sel;

  rr_arbiter2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_id   (arb_id)
  );

  assign req0_ready = (state == ST_IDLE) && arb_grant[0];
  assign req1_ready = (state == ST_IDLE) && arb_grant[1];
  assign accept     = req0_ready || req1_ready;

  // Subtraction is folded in at accept time (b inverted, cin forced), so the
  // operand registers always hold exactly what the adder sees.
  always_comb begin
    sel_a   = arb_id ? req1_a   : req0_a;
    sel_b   = arb_id ? req1_b   : req0_b;
    sel_cin = arb_id ? req1_cin : req0_cin;
`ifdef ADDER_SEQ_SUB_EN
    sel_sub = arb_id ? req1_sub : req0_sub;
`else
    sel_sub = 1'b0;
`endif
    if (sel_sub) begin
      sel_b   = ~sel_b;
      sel_cin = 1'b1;
    end
  end

  assign rsp_ready_sel = gid ? rsp1_ready : rsp0_ready;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      gid        <= 1'b0;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a       <= sel_a;
            op_b       <= sel_b;
            op_cin     <= sel_cin;
            gid        <= arb_id;
            last_grant <= arb_id;
            cnt        <= '0;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            res_sum  <= add_sum;
            res_cout <= add_cout;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_sel) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign add_a      = op_a;
  assign add_b      = op_b;
  assign add_cin    = op_cin;
  assign busy       = (state != ST_IDLE);
  assign rsp0_valid = (state == ST_RESP) && (gid == 1'b0);
  assign rsp1_valid = (state == ST_RESP) && (gid == 1'b1);
  assign rsp0_sum   = res_sum;
  assign rsp0_cout  = res_cout;
  assign rsp1_sum   = res_sum;
  assign rsp1_cout  = res_cout;

  // A pending request must keep valid and operands until it is accepted.
  a_req0_hold: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_i)
    (req0_valid && !req0_ready) |=>
      (req0_valid && $stable(req0_a) && $stable(req0_b) && $stable(req0_cin)));
  a_req1_hold: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_i)
    (req1_valid && !req1_ready) |=>
      (req1_valid && $stable(req1_a) && $stable(req1_b) && $stable(req1_cin)));

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed self-checking bench for adder_seq_ctrl with a behavioural adder.
module tb_adder_seq_ctrl;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        req0_valid, req0_ready, req0_cin, req0_sub;
  logic        req1_valid, req1_ready, req1_cin, req1_sub;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp0_cout;
  logic        rsp1_valid, rsp1_ready, rsp1_cout;
  logic [31:0] rsp0_sum, rsp1_sum;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  adder_seq_ctrl #(.WIDTH(32), .ADD_LAT(2)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
`ifdef ADDER_SEQ_SUB_EN
    .req0_sub   (req0_sub),
    .req1_sub   (req1_sub),
`endif
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_sum   (rsp0_sum),
    .rsp0_cout  (rsp0_cout),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_sum   (rsp1_sum),
    .rsp1_cout  (rsp1_cout),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .busy       (busy)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge wb_clk_i);
    #1;
  endtask

  always @(negedge wb_clk_i) begin
    if (wb_rst_i === 1'b1) chk("ready_excl", 64'(req0_ready & req1_ready), 64'd0);
  end

  task automatic run_op(input int g, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [31:0] exp_sum,
                        input logic exp_cout, input string tag);
    int k;
    int lat;
    if (g == 0) begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub; req1_valid = 1'b1;
    end
    #1;
    k = 0;
    while (!(g == 0 ? req0_ready : req1_ready) && k < 20) begin
      cyc(); #1; k++;
    end
    chk({tag, "_ready"}, 64'(g == 0 ? req0_ready : req1_ready), 64'd1);
    chk({tag, "_other_ready"}, 64'(g == 0 ? req1_ready : req0_ready), 64'd0);
    cyc();
    if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    #1;
    lat = 1;
    while (!(g == 0 ? rsp0_valid : rsp1_valid) && lat < 20) begin
      cyc(); lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd3);
    chk({tag, "_other_rsp"}, 64'(g == 0 ? rsp1_valid : rsp0_valid), 64'd0);
    chk({tag, "_sum"}, 64'(g == 0 ? rsp0_sum : rsp1_sum), 64'(exp_sum));
    chk({tag, "_cout"}, 64'(g == 0 ? rsp0_cout : rsp1_cout), 64'(exp_cout));
    if (g == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    chk({tag, "_rsp_drop"}, 64'(rsp0_valid | rsp1_valid), 64'd0);
  endtask

  initial begin : main
    int k;
    int exp_g;
    logic saw_rsp;
    wb_rst_i = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_sub = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_add", {add_cin, add_a, add_b[30:0]}, 64'd0);
    chk("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    chk("rst_rsp_data", {rsp0_cout, rsp1_cout, rsp0_sum, rsp1_sum[29:0]}, 64'd0);
    wb_rst_i = 1'b1;
    cyc();

    // Single add with wrap-around; watch the adder inputs through EXEC.
    req0_a = 32'hFFFF_FFFF; req0_b = 32'h1; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    chk("single_ready", 64'({req0_ready, req1_ready}), 64'd2);
    cyc();
    req0_valid = 1'b0;
    #1;
    chk("single_exec1", {busy, req0_ready, rsp0_valid, add_a}, {3'b100, 32'hFFFF_FFFF});
    cyc();
    chk("single_exec2", {busy, rsp0_valid, add_a, add_b[29:0]}, {2'b10, 32'hFFFF_FFFF, 30'd1});
    cyc();
    chk("single_rsp", {rsp0_valid, rsp1_valid, rsp0_cout, rsp0_sum}, {3'b101, 32'h0});
    rsp0_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0;
    #1;
    chk("single_done", {busy, rsp0_valid, add_a}, {2'b00, 32'hFFFF_FFFF});

    // Contention straight after reset: requester 0 wins first.
    wb_rst_i = 1'b0;
    cyc();
    wb_rst_i = 1'b1;
    req0_a = 32'd3;  req0_b = 32'd4;  req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 32'd10; req1_b = 32'd20; req1_cin = 1'b0; req1_valid = 1'b1;
    #1;
    chk("cont_first", 64'({req1_ready, req0_ready}), 64'd1);
    cyc();
    req0_valid = 1'b0;
    #1;
    chk("cont_exec_ready", 64'({req1_ready, req0_ready}), 64'd0);
    cyc(); cyc();
    chk("cont_rsp0", {rsp1_valid, rsp0_valid, rsp0_sum}, {2'b01, 32'd7});
    rsp0_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0;
    #1;
    chk("cont_second", 64'({req1_ready, req0_ready}), 64'd2);
    cyc();
    req1_valid = 1'b0;
    cyc(); cyc();
    chk("cont_rsp1", {rsp1_valid, rsp0_valid, rsp1_sum}, {2'b10, 32'd30});
    rsp1_ready = 1'b1;
    cyc();
    rsp1_ready = 1'b0;

    // Fairness: both requesting, grants alternate 0,1,0,1.
    req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
    req1_a = 32'd2; req1_b = 32'd2; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_g = i % 2;
      k = 0;
      while (!(req0_ready || req1_ready) && k < 20) begin cyc(); #1; k++; end
      chk($sformatf("fair%0d_grant", i), 64'({req1_ready, req0_ready}),
          (exp_g == 1) ? 64'd2 : 64'd1);
      cyc();
      if (i >= 2) begin
        if (exp_g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      end
      #1;
      k = 0;
      while (!(rsp0_valid || rsp1_valid) && k < 20) begin cyc(); #1; k++; end
      chk($sformatf("fair%0d_rsp", i),
          {rsp1_valid, rsp0_valid, (exp_g == 1) ? rsp1_sum : rsp0_sum},
          (exp_g == 1) ? {2'b10, 32'd4} : {2'b01, 32'd2});
      cyc();
      #1;
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Requester 0 alone, three back-to-back grants.
    run_op(0, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, "solo_a");
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, "solo_b");
    run_op(0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, "solo_c");

    // Backpressure on response 0 with requester 1 waiting.
    req0_a = 32'h1234_5678; req0_b = 32'h1111_1111; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    cyc();
    req0_valid = 1'b0;
    req1_a = 32'd100; req1_b = 32'd200; req1_cin = 1'b0; req1_valid = 1'b1;
    cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d", i), {busy, rsp0_valid, req1_ready, rsp0_cout, rsp0_sum},
          {4'b1100, 32'h2345_6789});
      cyc();
    end
    rsp0_ready = 1'b1;
    #1;
    chk("bp_xfer_no_accept", 64'(req1_ready), 64'd0);
    cyc();
    rsp0_ready = 1'b0;
    #1;
    chk("bp_after_xfer", 64'({rsp0_valid, req1_ready}), 64'd1);
    cyc();
    req1_valid = 1'b0;
    cyc(); cyc();
    chk("bp_rsp1", {rsp1_valid, rsp1_cout, rsp1_sum}, {2'b10, 32'h12C});
    rsp1_ready = 1'b1;
    cyc();
    rsp1_ready = 1'b0;

    // Reset during EXEC discards the operation.
    req0_a = 32'd1; req0_b = 32'd2; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    cyc();
    req0_valid = 1'b0;
    wb_rst_i = 1'b0;
    cyc();
    wb_rst_i = 1'b1;
    chk("mid_rst_outputs", {busy, rsp0_valid, rsp1_valid, add_cin, add_a, add_b[27:0]}, 64'd0);
    chk("mid_rst_rsp", {rsp0_cout, rsp0_sum}, 64'd0);
    saw_rsp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      saw_rsp = saw_rsp | rsp0_valid | rsp1_valid;
      cyc();
    end
    chk("mid_rst_no_rsp", 64'(saw_rsp), 64'd0);
    run_op(0, 32'd9, 32'd9, 1'b1, 1'b0, 32'd19, 1'b0, "post_rst");

`ifdef ADDER_SEQ_SUB_EN
    run_op(1, 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, "sub_neg");
    run_op(1, 32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1, "sub_pos");
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, %0d/%0d checks passed",
             n_checks - n_fail, n_checks);
    $fatal(1);
  end

endmodule
